// File: rtl/seg7_scan_drv.sv
// Time-multiplexed driver for a 3-digit common-anode 7-segment display fed by a packed BCD value.
// Each frame shows ones, tens, then hundreds, with an optional all-off gap before each digit.
module seg7_scan_drv #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500,
    parameter int LZB       = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [11:0] num_bcd,
    output logic [6:0]  seg,
    output logic [2:0]  dig_sel,
    output logic        frame_done,
    output logic        bcd_err
);

    localparam int CMAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? (BLANK_CYC - 1) : 0);
    localparam logic HAS_BLANK = (BLANK_CYC > 32'sd0);
    localparam logic LZB_EN    = (LZB != 32'sd0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [11:0] snap_q, snap_d;
    logic [6:0]  seg_q, seg_d;
    logic [2:0]  dig_q, dig_d;
    logic        fd_q, fd_d;
    logic        err_q, err_d;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b100_0000;
            4'd1:    s = 7'b111_1001;
            4'd2:    s = 7'b010_0100;
            4'd3:    s = 7'b011_0000;
            4'd4:    s = 7'b001_1001;
            4'd5:    s = 7'b001_0010;
            4'd6:    s = 7'b000_0010;
            4'd7:    s = 7'b111_1000;
            4'd8:    s = 7'b000_0000;
            4'd9:    s = 7'b001_0000;
            default: s = 7'b111_1111;
        endcase
        return s;
    endfunction

    function automatic logic has_bad_nibble(input logic [11:0] v);
        return (v[11:8] > 4'd9) || (v[7:4] > 4'd9) || (v[3:0] > 4'd9);
    endfunction

    // Segment pattern for digit slot i, applying leading-zero blanking on the upper two digits.
    function automatic logic [6:0] digit_seg(input logic [11:0] v, input logic [1:0] i);
        logic [3:0] nib;
        logic       blank;
        nib   = 4'hF;
        blank = 1'b0;
        case (i)
            2'd0: begin
                nib   = v[3:0];
                blank = 1'b0;
            end
            2'd1: begin
                nib   = v[7:4];
                blank = LZB_EN && (v[11:8] == 4'd0) && (v[7:4] == 4'd0);
            end
            2'd2: begin
                nib   = v[11:8];
                blank = LZB_EN && (v[11:8] == 4'd0);
            end
            default: begin
                nib   = 4'hF;
                blank = 1'b1;
            end
        endcase
        return blank ? 7'h7F : seg_decode(nib);
    endfunction

    // State, counters, snapshot and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
            snap_q  <= 12'h000;
            seg_q   <= 7'h7F;
            dig_q   <= 3'b111;
            fd_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
            fd_q    <= fd_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; outputs are computed from the next state so they line up with it.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        err_d   = err_q;
        fd_d    = 1'b0;
        seg_d   = 7'h7F;
        dig_d   = 3'b111;

        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    snap_d  = num_bcd;
                    err_d   = has_bad_nibble(num_bcd);
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                    state_d = HAS_BLANK ? ST_BLANK : ST_SHOW;
                end
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_SHOW;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == SCAN_LAST) begin
                        cnt_d   = '0;
                        state_d = HAS_BLANK ? ST_BLANK : ST_SHOW;
                        if (idx_q == 2'd2) begin
                            // Frame wrap: the only point besides enable where new input is taken.
                            idx_d  = 2'd0;
                            fd_d   = 1'b1;
                            snap_d = num_bcd;
                            err_d  = has_bad_nibble(num_bcd);
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (state_d == ST_SHOW) begin
            dig_d = ~(3'b001 << idx_d);
            seg_d = digit_seg(snap_d, idx_d);
        end else begin
            dig_d = 3'b111;
            seg_d = 7'h7F;
        end
    end

    assign seg        = seg_q;
    assign dig_sel    = dig_q;
    assign frame_done = fd_q;
    assign bcd_err    = err_q;

endmodule

// File: tb/tb_seg7_scan_drv.sv
// Scoreboard bench for seg7_scan_drv: three instances (blanking+LZB, no LZB, no blanking),
// expected per-cycle outputs queued when stimulus is applied and popped one per clock.
module tb_seg7_scan_drv;

    typedef struct packed {
        logic [6:0] seg;
        logic [2:0] dig;
        logic       fd;
        logic       err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en0, en1, en2;
    logic [11:0] num;

    logic [6:0] seg0, seg1, seg2;
    logic [2:0] dig0, dig1, dig2;
    logic       fd0, fd1, fd2;
    logic       err0, err1, err2;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int   checks = 0;
    int   errors = 0;
    string tag = "init";

    always #5 clk = ~clk;

    seg7_scan_drv #(.SCAN_DIV(4), .BLANK_CYC(2), .LZB(1)) u0 (
        .clk(clk), .rst(rst), .en(en0), .num_bcd(num),
        .seg(seg0), .dig_sel(dig0), .frame_done(fd0), .bcd_err(err0));

    seg7_scan_drv #(.SCAN_DIV(4), .BLANK_CYC(2), .LZB(0)) u1 (
        .clk(clk), .rst(rst), .en(en1), .num_bcd(num),
        .seg(seg1), .dig_sel(dig1), .frame_done(fd1), .bcd_err(err1));

    seg7_scan_drv #(.SCAN_DIV(4), .BLANK_CYC(0), .LZB(1)) u2 (
        .clk(clk), .rst(rst), .en(en2), .num_bcd(num),
        .seg(seg2), .dig_sel(dig2), .frame_done(fd2), .bcd_err(err2));

    function automatic exp_t mk(input logic [6:0] s, input logic [2:0] d,
                                input logic f, input logic e);
        exp_t r;
        r.seg = s;
        r.dig = d;
        r.fd  = f;
        r.err = e;
        return r;
    endfunction

    task automatic cmp(input int d, input exp_t obs, input exp_t e);
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s dut%0d t=%0t got seg=%h dig=%b fd=%b err=%b expected seg=%h dig=%b fd=%b err=%b",
                   tag, d, $time, obs.seg, obs.dig, obs.fd, obs.err, e.seg, e.dig, e.fd, e.err);
        end
    endtask

    task automatic push(input int d, input exp_t e, input int n);
        for (int i = 0; i < n; i++) begin
            case (d)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
    endtask

    // One digit slot: nb off cycles then 4 lit cycles; frame_done on the slot's first cycle if fdf.
    task automatic push_slot(input int d, input logic [6:0] s, input logic [2:0] dg,
                             input logic e, input logic fdf, input int nb);
        for (int i = 0; i < nb; i++)
            push(d, mk(7'h7F, 3'b111, fdf && (i == 0), e), 1);
        for (int i = 0; i < 4; i++)
            push(d, mk(s, dg, fdf && (nb == 0) && (i == 0), e), 1);
    endtask

    task automatic push_frame(input int d, input logic [6:0] so, input logic [6:0] st,
                              input logic [6:0] sh, input logic e, input logic fdf, input int nb);
        push_slot(d, so, 3'b110, e, fdf, nb);
        push_slot(d, st, 3'b101, e, 1'b0, nb);
        push_slot(d, sh, 3'b011, e, 1'b0, nb);
    endtask

    task automatic run(input int n);
        exp_t e;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                cmp(0, mk(seg0, dig0, fd0, err0), e);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                cmp(1, mk(seg1, dig1, fd1, err1), e);
            end
            if (q2.size() > 0) begin
                e = q2.pop_front();
                cmp(2, mk(seg2, dig2, fd2, err2), e);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        en0 = 1'b1;
        en1 = 1'b0;
        en2 = 1'b0;
        num = 12'h123;

        tag = "reset_hold";
        @(posedge clk); #1;
        cmp(0, mk(seg0, dig0, fd0, err0), mk(7'h7F, 3'b111, 1'b0, 1'b0));
        @(posedge clk); #1;
        cmp(0, mk(seg0, dig0, fd0, err0), mk(7'h7F, 3'b111, 1'b0, 1'b0));

        tag = "normal_123";
        rst = 1'b1;
        push_frame(0, 7'h30, 7'h24, 7'h79, 1'b0, 1'b0, 2);
        push_frame(0, 7'h30, 7'h24, 7'h79, 1'b0, 1'b1, 2);
        run(36);

        // Change input during the ones slot: this frame keeps 1/2/3, the next shows 1/4/9.
        tag = "snapshot";
        push(0, mk(7'h7F, 3'b111, 1'b1, 1'b0), 1);
        push(0, mk(7'h7F, 3'b111, 1'b0, 1'b0), 1);
        push(0, mk(7'h30, 3'b110, 1'b0, 1'b0), 2);
        run(4);
        num = 12'h149;
        push(0, mk(7'h30, 3'b110, 1'b0, 1'b0), 2);
        push_slot(0, 7'h24, 3'b101, 1'b0, 1'b0, 2);
        push_slot(0, 7'h79, 3'b011, 1'b0, 1'b0, 2);
        push_frame(0, 7'h10, 7'h19, 7'h79, 1'b0, 1'b1, 2);
        run(32);

        tag = "enable_drop";
        push_slot(0, 7'h10, 3'b110, 1'b0, 1'b1, 2);
        push(0, mk(7'h7F, 3'b111, 1'b0, 1'b0), 2);
        push(0, mk(7'h19, 3'b101, 1'b0, 1'b0), 2);
        run(10);
        en0 = 1'b0;
        push(0, mk(7'h7F, 3'b111, 1'b0, 1'b0), 3);
        run(3);

        tag = "reenable_lzb";
        num = 12'h005;
        en0 = 1'b1;
        push_frame(0, 7'h12, 7'h7F, 7'h7F, 1'b0, 1'b0, 2);
        push_frame(0, 7'h40, 7'h12, 7'h7F, 1'b0, 1'b1, 2);
        run(1);
        num = 12'h050;
        run(18);

        tag = "bcd_err";
        num = 12'h1A3;
        run(17);
        push_frame(0, 7'h30, 7'h7F, 7'h79, 1'b1, 1'b1, 2);
        push(0, mk(7'h7F, 3'b111, 1'b1, 1'b1), 1);
        push(0, mk(7'h7F, 3'b111, 1'b0, 1'b1), 1);
        push(0, mk(7'h30, 3'b110, 1'b0, 1'b1), 1);
        run(21);

        tag = "async_reset_mid_show";
        #2;
        rst = 1'b0;
        #1;
        cmp(0, mk(seg0, dig0, fd0, err0), mk(7'h7F, 3'b111, 1'b0, 1'b0));
        en0 = 1'b0;
        #1;
        rst = 1'b1;

        tag = "no_lzb_005";
        num = 12'h005;
        en1 = 1'b1;
        push_frame(1, 7'h12, 7'h40, 7'h40, 1'b0, 1'b0, 2);
        run(18);

        tag = "no_blank_123";
        en1 = 1'b0;
        num = 12'h123;
        en2 = 1'b1;
        push_frame(2, 7'h30, 7'h24, 7'h79, 1'b0, 1'b0, 0);
        push_slot(2, 7'h30, 3'b110, 1'b0, 1'b1, 0);
        run(16);

        tag = "queues_drained";
        checks++;
        assert ((q0.size() + q1.size() + q2.size()) == 0) else begin
            errors++;
            $error("FAIL %s got %0d pending entries expected 0", tag,
                   q0.size() + q1.size() + q2.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
